// File: rtl/mac_tx_arbiter_if.sv
// Stream bundle around the TX arbiter: N requester streams in, one MAC TX stream out.
// master = the arbiter itself; slave = the requesters plus MAC TX that surround it.
interface mac_tx_arbiter_if #(
  parameter int N_PORTS   = 4,
  parameter int N_SYMBOLS = 8,
  parameter int W_SYMBOL  = 8
);
  logic [N_PORTS-1:0]                               s_axis_tvalid;
  logic [N_PORTS-1:0][N_SYMBOLS-1:0]                s_axis_tkeep;
  logic [N_PORTS-1:0][N_SYMBOLS-1:0][W_SYMBOL-1:0]  s_axis_tdata;
  logic [N_PORTS-1:0]                               s_axis_tlast;
  logic [N_PORTS-1:0]                               s_axis_tready;

  logic                                             m_axis_tvalid;
  logic [N_SYMBOLS-1:0]                             m_axis_tkeep;
  logic [N_SYMBOLS-1:0][W_SYMBOL-1:0]               m_axis_tdata;
  logic                                             m_axis_tlast;
  logic                                             m_axis_tready;

  modport master (
    input  s_axis_tvalid, s_axis_tkeep, s_axis_tdata, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_tkeep, m_axis_tdata, m_axis_tlast
  );

  modport slave (
    output s_axis_tvalid, s_axis_tkeep, s_axis_tdata, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tvalid, m_axis_tkeep, m_axis_tdata, m_axis_tlast
  );
endinterface

// File: rtl/mac_tx_arbiter.sv
// Packet-level round-robin arbiter in front of the MAC TX; a grant is held for a whole frame.
//   state  | meaning
//   S_IDLE | outputs quiet, pick next requester after last_grant
//   S_BUSY | granted stream passed through until its tlast beat transfers
module mac_tx_arbiter #(
  parameter int N_PORTS = 4,
  parameter int W_PORT  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_clk_en,
  mac_tx_arbiter_if.master  axis,
  output logic [W_PORT-1:0] o_grant,
  output logic              o_busy,
  output logic              o_frame_done
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t              r_state;
  logic [W_PORT-1:0]   r_grant;
  logic [W_PORT-1:0]   r_last_grant;
  logic                r_busy;
  logic                r_frame_done;

  state_t              w_state_nxt;
  logic [W_PORT-1:0]   w_grant_nxt;
  logic [W_PORT-1:0]   w_last_grant_nxt;
  logic                w_frame_done_nxt;
  logic                w_req_found;
  logic [W_PORT-1:0]   w_req_sel;
  logic [W_PORT-1:0]   w_scan;
  logic                w_xfer;

  // Rotating scan: last_grant+1 first, last_grant itself last.
  always_comb begin
    w_req_found = 1'b0;
    w_req_sel   = '0;
    w_scan      = '0;
    for (int k = 1; k <= N_PORTS; k++) begin
      w_scan = W_PORT'((int'(r_last_grant) + k) % N_PORTS);
      if (!w_req_found && axis.s_axis_tvalid[w_scan]) begin
        w_req_found = 1'b1;
        w_req_sel   = w_scan;
      end
    end
  end

  always_comb begin
    axis.m_axis_tvalid = 1'b0;
    axis.m_axis_tkeep  = '0;
    axis.m_axis_tdata  = '0;
    axis.m_axis_tlast  = 1'b0;
    axis.s_axis_tready = '0;
    if (r_state == S_BUSY) begin
      axis.m_axis_tvalid          = axis.s_axis_tvalid[r_grant];
      axis.m_axis_tkeep           = axis.s_axis_tkeep[r_grant];
      axis.m_axis_tdata           = axis.s_axis_tdata[r_grant];
      axis.m_axis_tlast           = axis.s_axis_tlast[r_grant];
      axis.s_axis_tready[r_grant] = axis.m_axis_tready & i_clk_en;
    end
  end

  assign w_xfer = axis.m_axis_tvalid & axis.m_axis_tready & i_clk_en;

  always_comb begin
    w_state_nxt      = r_state;
    w_grant_nxt      = r_grant;
    w_last_grant_nxt = r_last_grant;
    w_frame_done_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req_found) begin
          w_state_nxt      = S_BUSY;
          w_grant_nxt      = w_req_sel;
          w_last_grant_nxt = w_req_sel;
        end
      end
      S_BUSY: begin
        if (w_xfer && axis.m_axis_tlast) begin
          w_state_nxt      = S_IDLE;
          w_frame_done_nxt = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // last_grant resets to the top port so port 0 wins the first arbitration.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_last_grant <= W_PORT'(N_PORTS - 1);
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else if (i_clk_en) begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_busy       <= (w_state_nxt == S_BUSY);
      r_frame_done <= w_frame_done_nxt;
    end
  end

  assign o_grant      = r_grant;
  assign o_busy       = r_busy;
  assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Bench for mac_tx_arbiter: directed scenarios followed by random traffic, checked every
// cycle against a frame-level round-robin reference model.
module tb_mac_tx_arbiter;
  localparam int NP = 4;
  localparam int NS = 4;
  localparam int WS = 8;
  localparam int WP = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clk_en = 1'b1;
  logic [WP-1:0] grant;
  logic          busy;
  logic          fdone;

  mac_tx_arbiter_if #(.N_PORTS(NP), .N_SYMBOLS(NS), .W_SYMBOL(WS)) axis ();

  mac_tx_arbiter #(.N_PORTS(NP), .W_PORT(WP)) dut (
    .i_clk(clk), .i_reset(rst), .i_clk_en(clk_en), .axis(axis),
    .o_grant(grant), .o_busy(busy), .o_frame_done(fdone)
  );

  always #5 clk = ~clk;

  // Source side: each port presents one frame at a time, beat by beat.
  bit src_act [NP];
  bit src_ven [NP];
  bit src_auto[NP];
  int src_len [NP];
  int src_beat[NP];
  int src_fno [NP];
  bit mt_ready;

  // Reference model state.
  bit mdl_busy;
  int mdl_port;
  int mdl_last;
  int mdl_grant;
  bit mdl_done;

  int checks = 0;
  int errors = 0;
  int dut_order[$];
  bit prev_busy;
  int exp_order[6] = '{0, 1, 3, 0, 1, 3};

  function automatic logic [NS*WS-1:0] beat_data(int p, int f, int b);
    return {8'(p), 8'(f), 8'(b), 8'(p * 37 + f * 11 + b * 5) ^ 8'h5A};
  endfunction

  function automatic logic [NS-1:0] keep_of(int p, int f, int b, int len);
    return (b == len - 1) ? NS'((f + p) % 15 + 1) : {NS{1'b1}};
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic start(int p, int len);
    src_act[p]  = 1'b1;
    src_len[p]  = len;
    src_beat[p] = 0;
    src_ven[p]  = 1'b1;
  endtask

  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      axis.s_axis_tvalid[p] = src_act[p] && src_ven[p];
      axis.s_axis_tdata[p]  = beat_data(p, src_fno[p], src_beat[p]);
      axis.s_axis_tkeep[p]  = keep_of(p, src_fno[p], src_beat[p], src_len[p]);
      axis.s_axis_tlast[p]  = (src_beat[p] == src_len[p] - 1);
    end
    axis.m_axis_tready = mt_ready;
  endtask

  task automatic model_reset();
    mdl_busy  = 1'b0;
    mdl_port  = 0;
    mdl_grant = 0;
    mdl_last  = NP - 1;
    mdl_done  = 1'b0;
  endtask

  // One cycle: drive, check at mid-low phase, advance model, step to next falling edge.
  task automatic tick();
    logic              ev, el;
    logic [NS*WS-1:0]  ed;
    logic [NS-1:0]     ek;
    logic [NP-1:0]     er;
    bit                sv[NP];
    int                p;
    bit                found;
    drive();
    #1;
    ev = 1'b0; ed = '0; ek = '0; el = 1'b0; er = '0;
    if (mdl_busy) begin
      p  = mdl_port;
      ev = src_act[p] && src_ven[p];
      ed = beat_data(p, src_fno[p], src_beat[p]);
      ek = keep_of(p, src_fno[p], src_beat[p], src_len[p]);
      el = (src_beat[p] == src_len[p] - 1);
      er = (mt_ready && clk_en) ? NP'(1 << p) : '0;
    end
    chk("m_tvalid", 64'(axis.m_axis_tvalid), 64'(ev));
    chk("m_tdata", 64'(axis.m_axis_tdata), 64'(ed));
    chk("m_tkeep", 64'(axis.m_axis_tkeep), 64'(ek));
    chk("m_tlast", 64'(axis.m_axis_tlast), 64'(el));
    chk("s_tready", 64'(axis.s_axis_tready), 64'(er));
    chk("o_busy", 64'(busy), 64'(mdl_busy));
    chk("o_grant", 64'(grant), 64'(mdl_grant));
    chk("o_frame_done", 64'(fdone), 64'(mdl_done));
    if (busy === 1'b1 && !prev_busy) dut_order.push_back(int'(grant));
    prev_busy = (busy === 1'b1);

    if (!rst && clk_en) begin
      for (int q = 0; q < NP; q++) sv[q] = src_act[q] && src_ven[q];
      mdl_done = 1'b0;
      if (mdl_busy) begin
        p = mdl_port;
        if (sv[p] && mt_ready) begin
          if (src_beat[p] == src_len[p] - 1) begin
            src_act[p] = 1'b0;
            src_fno[p]++;
            mdl_busy   = 1'b0;
            mdl_done   = 1'b1;
            if (src_auto[p]) start(p, src_len[p]);
          end else begin
            src_beat[p]++;
          end
        end
      end else begin
        found = 1'b0;
        for (int k = 1; k <= NP; k++) begin
          p = (mdl_last + k) % NP;
          if (!found && sv[p]) begin
            found     = 1'b1;
            mdl_busy  = 1'b1;
            mdl_port  = p;
            mdl_grant = p;
            mdl_last  = p;
          end
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    mt_ready = 1'b1;
    clk_en   = 1'b1;
    for (int p = 0; p < NP; p++) begin
      src_auto[p] = 1'b0;
      src_ven[p]  = 1'b1;
    end
    for (int i = 0; i < 80; i++) begin
      if (mdl_busy || src_act[0] || src_act[1] || src_act[2] || src_act[3]) tick();
    end
    tick();
    chk("drain_idle", 64'(busy), 64'(0));
  endtask

  // Asynchronous reset between edges: outputs must clear before any clock edge.
  task automatic async_reset();
    rst = 1'b1;
    #2;
    chk("rst_m_tvalid", 64'(axis.m_axis_tvalid), 64'(0));
    chk("rst_m_tdata", 64'(axis.m_axis_tdata), 64'(0));
    chk("rst_s_tready", 64'(axis.s_axis_tready), 64'(0));
    chk("rst_o_busy", 64'(busy), 64'(0));
    chk("rst_o_grant", 64'(grant), 64'(0));
    chk("rst_o_frame_done", 64'(fdone), 64'(0));
    model_reset();
    for (int p = 0; p < NP; p++) src_beat[p] = 0;
    @(negedge clk);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    for (int p = 0; p < NP; p++) begin
      src_act[p] = 0; src_ven[p] = 1; src_auto[p] = 0;
      src_len[p] = 1; src_beat[p] = 0; src_fno[p] = p * 16;
    end
    mt_ready = 1'b1;
    model_reset();
    prev_busy = 1'b0;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;

    // Single 3-beat frame from port 0.
    start(0, 3);
    repeat (6) tick();

    // Ports 0, 1, 3 request back-to-back 2-beat frames from reset.
    async_reset();
    dut_order.delete();
    for (int p = 0; p < NP; p++) if (p != 2) begin
      src_auto[p] = 1'b1;
      start(p, 2);
    end
    repeat (18) tick();
    for (int i = 0; i < 6; i++)
      chk("grant_order", 64'((dut_order.size() > i) ? dut_order[i] : -1), 64'(exp_order[i]));
    drain();

    // Port 2 locked in while ready toggles and it drops valid; port 1 waits.
    start(2, 4);
    tick();
    start(1, 2);
    for (int i = 0; i < 10; i++) begin
      mt_ready   = (i % 2 == 0);
      src_ven[2] = !(i == 3 || i == 4);
      tick();
    end
    drain();

    // Clock enable 1,0,1,0 through a 4-beat frame.
    start(0, 4);
    tick();
    for (int i = 0; i < 10; i++) begin
      clk_en = (i % 2 == 0);
      tick();
    end
    drain();

    // Reset on beat 2 of 5 from port 1 while port 0 waits.
    start(1, 5);
    tick();
    start(0, 2);
    for (int i = 0; i < 10; i++) if (src_beat[1] < 2) tick();
    async_reset();
    tick();
    chk("post_rst_grant0", 64'(grant), 64'(0));
    drain();

    // Port 3 single-beat frame while port 0 waits.
    start(0, 2);
    start(3, 1);
    repeat (3) tick();
    drain();

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      clk_en   = ($urandom_range(0, 7) != 0);
      mt_ready = ($urandom_range(0, 3) != 0);
      for (int p = 0; p < NP; p++) begin
        if (!src_act[p] && $urandom_range(0, 5) == 0) start(p, int'($urandom_range(1, 5)));
        src_ven[p] = ($urandom_range(0, 7) != 0);
      end
      if ($urandom_range(0, 299) == 0) async_reset();
      else tick();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mac_tx_arbiter.md
# mac_tx_arbiter

Packet-level round-robin arbiter that shares the single MAC transmit path (`mac_tx_top` slave AXI-Stream) between `N_PORTS` AXI-Stream requesters. It sits directly in front of the MAC TX and behind the per-source packet queues. A grant is held for a whole frame, from first beat to the accepted `tlast` beat, so frames are never interleaved on the XGMII. Data widths come from the `mac_params` package: `N_SYMBOLS` lanes of `W_SYMBOL` bits.

## Interface
- `N_PORTS`, default 4: number of requesters, range 1..16.
- `W_PORT`, default `$clog2(N_PORTS)` (minimum 1): width of the grant index.
- `i_clk`, in, 1: TX clock, the same clock as `mac_tx_top`.
- `i_reset`, in, 1: asynchronous, active-high reset.
- `i_clk_en`, in, 1: clock enable, the same enable as `mac_tx_top`. All state and all transfers qualify on it.
- `s_axis_tvalid`, in, `[N_PORTS]`: per-requester valid.
- `s_axis_tkeep`, in, `[N_PORTS][N_SYMBOLS]`: per-requester byte keep.
- `s_axis_tdata`, in, `[N_PORTS][N_SYMBOLS][W_SYMBOL]`: per-requester data.
- `s_axis_tlast`, in, `[N_PORTS]`: per-requester end of frame.
- `s_axis_tready`, out, `[N_PORTS]`: per-requester ready.
- `m_axis_tvalid`, `m_axis_tkeep`, `m_axis_tdata`, `m_axis_tlast`, out: master stream to the MAC TX, with the widths above.
- `m_axis_tready`, in, 1: ready from the MAC TX.
- `o_grant`, out, `W_PORT`: index of the current or most recent grant.
- `o_busy`, out, 1: high while a frame is granted.
- `o_frame_done`, out, 1: one-cycle pulse when a frame's `tlast` beat transfers.

## Operation
- Transfer definition: `m_axis_tvalid & m_axis_tready & i_clk_en`.
- Two states: IDLE and BUSY. State advances only on cycles with `i_clk_en=1`. When `i_clk_en=0`, every register holds.
- IDLE:
  - Master outputs are forced to 0 and all `s_axis_tready` bits are 0.
  - If any `s_axis_tvalid` bit is set, select the first asserted requester, scanning upward from `last_grant+1` and wrapping modulo `N_PORTS`.
  - Register the selection into `grant` and `last_grant`, then go to BUSY.
- BUSY:
  - `m_axis_*` = `s_axis_*[grant]`, passed through combinationally with no data register.
  - `s_axis_tready[grant]` = `m_axis_tready & i_clk_en`. All other ready bits are 0.
  - On a transfer with `m_axis_tlast=1`: pulse `o_frame_done` on the next cycle and return to IDLE.
- The grant is locked for the whole frame. If the granted requester drops `tvalid` mid-frame, `m_axis_tvalid` goes low and the grant is held. Other requesters stay blocked.
- Fairness: the requester just served gets lowest priority in the next arbitration. Any requester that keeps `tvalid` high is served within `N_PORTS` frames.
- `N_PORTS=1`: `o_grant` is always 0 and the arbitration logic degenerates to the IDLE/BUSY pair.
- `tkeep` and `tlast` are not checked or altered. Frame validity is the responsibility of the MAC TX.

## Timing
- Reset values:
  - state = IDLE, `grant` = 0, `last_grant` = `N_PORTS-1` (so port 0 has first priority).
  - `m_axis_tvalid` = 0, `m_axis_tlast` = 0, `m_axis_tkeep` = 0, `m_axis_tdata` = 0.
  - `s_axis_tready` = 0, `o_grant` = 0, `o_busy` = 0, `o_frame_done` = 0.
- Arbitration latency: request seen in IDLE at enabled edge N gives BUSY and a valid master beat in cycle N+1.
- Gap between back-to-back frames: exactly one enabled cycle, the IDLE arbitration cycle, after the `tlast` transfer. This applies even when the same port re-requests.
- Through path in BUSY: zero-cycle combinational path for data, valid and ready.
- Simultaneous events: a new `tvalid` arriving in the same cycle as the `tlast` transfer is not considered until the following IDLE cycle.
- `i_clk_en=0` in BUSY: no transfer, `s_axis_tready` is 0, state and grant hold. `m_axis_tvalid` still mirrors the granted requester.
- Reset asserted mid-frame: immediate return to reset values, with no `o_frame_done`. The partial frame is abandoned. The requester must restart the frame.
- `o_busy` is registered and equals (state==BUSY). `o_grant` is registered.

## Test plan
- Single port 0 sends a 3-beat frame, `m_axis_tready=1`, `i_clk_en=1` -> `m_axis_tvalid` rises 1 cycle after the request. Beats pass unchanged. `o_frame_done` pulses once. `o_busy` falls after `tlast`.
- Ports 0, 1 and 3 all hold 2-beat frames continuously from reset -> grant order 0, 1, 3, 0, 1, 3. Exactly one idle cycle between frames. No interleaved beats.
- Port 2 is granted, then `m_axis_tready` toggles 1/0 and port 2 drops `tvalid` for 2 cycles mid-frame -> the grant stays on 2 and port 1's request stays blocked. Beat count and order are preserved, and `s_axis_tready[1]` stays 0.
- `i_clk_en` pattern 1,0,1,0 during a 4-beat frame -> transfers only on enabled cycles. State holds on disabled cycles. The 4 beats are delivered with `o_frame_done` pulsed once.
- Reset asserted on beat 2 of 5 from port 1 -> all outputs reach reset values asynchronously. After release, port 0 (if requesting) wins before port 1.
- Port 3 sends a single-beat frame (`tvalid` and `tlast` in the first beat) while port 0 is waiting -> port 3 is served for 1 cycle, then port 0 is granted after one IDLE cycle.
